// File: rtl/mcac_pkg.sv
// Shared constants and types for the G.726 predictor-coefficient update.
package mcac_pkg;
    localparam int NTAPS = 6;
    localparam int BW = 16;
    localparam logic [BW-1:0] UGB_POS = 16'h0080;
    localparam logic [BW-1:0] UGB_NEG = 16'hFF80;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} upb_state_t;
endpackage

// File: rtl/upb_tap.sv
// One-tap BP = B + UGB + ULB; build with UPB_SAT_EN to saturate instead of wrap.
module upb_tap
    import mcac_pkg::*;
(
    input  logic [BW-1:0] b,
    input  logic          sgn,
    input  logic          dq_nz,
    output logic [BW-1:0] bp
);
    logic        [BW-1:0] ugb;
    logic signed [BW-1:0] shr;
    logic        [BW-1:0] ulb;
    logic        [BW+1:0] sum;

    always_comb begin
        ugb = '0;
        if (dq_nz) ugb = sgn ? UGB_NEG : UGB_POS;
        shr = $signed(b) >>> 8;
        ulb = -shr;
        sum = {{2{b[BW-1]}}, b}
            + {{2{ugb[BW-1]}}, ugb}
            + {{2{ulb[BW-1]}}, ulb};
    end

`ifdef UPB_SAT_EN
    // Overflow whenever the top three bits of the 18-bit sum disagree.
    always_comb begin
        bp = sum[BW-1:0];
        if (sum[BW+1:BW-1] != {3{sum[BW+1]}})
            bp = sum[BW+1] ? 16'h8000 : 16'h7FFF;
    end
`else
    logic unused_hi;
    assign unused_hi = ^sum[BW+1:BW];
    assign bp = sum[BW-1:0];
`endif
endmodule

// File: rtl/upb_serial.sv
// Serial six-tap predictor coefficient update (FSM, tap counter, capture).
module upb_serial
    import mcac_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          dq_nz,
    input  logic          dqs,
    input  logic [5:0]    dqsn,
    output logic          b_re,
    output logic [2:0]    b_raddr,
    input  logic [BW-1:0] b_rdata,
    output logic          b_we,
    output logic [2:0]    b_waddr,
    output logic [BW-1:0] b_wdata,
    output logic          busy,
    output logic          done,
    input  logic          scan_in0,
    input  logic          scan_in1,
    input  logic          scan_in2,
    input  logic          scan_in3,
    input  logic          scan_in4,
    input  logic          scan_enable,
    input  logic          test_mode,
    output logic          scan_out0,
    output logic          scan_out1,
    output logic          scan_out2,
    output logic          scan_out3,
    output logic          scan_out4
);
    localparam logic [2:0] LAST = 3'(NTAPS - 1);

    upb_state_t    state, nxt;
    logic [2:0]    cnt;
    logic          cap_nz;
    logic          cap_dqs;
    logic [5:0]    cap_dqsn;
    logic          wr_pend;
    logic [2:0]    waddr_q;
    logic [5:0]    dqsn_sh;
    logic          sgn;
    logic [BW-1:0] bp;

    logic unused_scan;
    assign unused_scan = ^{scan_in0, scan_in1, scan_in2, scan_in3,
                           scan_in4, scan_enable, test_mode};
    assign scan_out0 = 1'b0;
    assign scan_out1 = 1'b0;
    assign scan_out2 = 1'b0;
    assign scan_out3 = 1'b0;
    assign scan_out4 = 1'b0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:    if (start) nxt = RUN;
            RUN:     if (cnt == LAST) nxt = DRAIN;
            DRAIN:   nxt = DONE;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Write side trails the read side by one cycle (read latency).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt      <= '0;
            cap_nz   <= 1'b0;
            cap_dqs  <= 1'b0;
            cap_dqsn <= '0;
            wr_pend  <= 1'b0;
            waddr_q  <= '0;
        end else begin
            if (state == IDLE && start) begin
                cap_nz   <= dq_nz;
                cap_dqs  <= dqs;
                cap_dqsn <= dqsn;
                cnt      <= '0;
            end else if (state == RUN) begin
                cnt <= (cnt == LAST) ? 3'd0 : cnt + 3'd1;
            end
            wr_pend <= (state == RUN);
            waddr_q <= (state == RUN) ? cnt : 3'd0;
        end
    end

    assign dqsn_sh = cap_dqsn >> waddr_q;
    assign sgn     = cap_dqs ^ dqsn_sh[0];

    upb_tap u_tap (
        .b     (b_rdata),
        .sgn   (sgn),
        .dq_nz (cap_nz),
        .bp    (bp)
    );

    always_comb begin
        b_re    = (state == RUN);
        b_raddr = b_re ? cnt : 3'd0;
        b_we    = wr_pend;
        b_waddr = wr_pend ? waddr_q : 3'd0;
        b_wdata = wr_pend ? bp : '0;
        busy    = (state != IDLE);
        done    = (state == DONE);
    end
endmodule
